// File: rtl/lcd_pkg.sv
// Shared LCD command codes, timing constants, state types and the nibble-to-ASCII
// mapping used by the HD44780 hex display.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CMD_DDRAM    = 8'h80;

  // Timing in microseconds; scaled by cycles-per-microsecond in each module.
  localparam int T_PWR_US       = 15000;
  localparam int T_SETUP_US     = 1;
  localparam int T_PULSE_US     = 1;
  localparam int T_HOLD_US      = 40;
  localparam int T_HOLD_LONG_US = 1640;
  localparam int T_CNT_MAX_US   = 16400;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SET_ADDR,
    ST_WRITE_CHAR
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } lcd_phase_e;

  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Sends one byte to the LCD bus: SETUP (EN low), PULSE (EN high), HOLD (EN low).
// A new start is accepted in the last HOLD cycle so bursts run back to back.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_US = 50
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  input  logic       iLONG,
  output logic       oDONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int CNT_W = $clog2(T_CNT_MAX_US * T_US + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST     = CNT_W'(T_SETUP_US * T_US - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST     = CNT_W'(T_PULSE_US * T_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST      = CNT_W'(T_HOLD_US * T_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LONG_LAST = CNT_W'(T_HOLD_LONG_US * T_US - 1);

  lcd_phase_e       phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             long_q, phase_end, accept;

  always_comb begin
    case (phase)
      PH_PULSE: cnt_last = PULSE_LAST;
      PH_HOLD:  cnt_last = long_q ? HOLD_LONG_LAST : HOLD_LAST;
      default:  cnt_last = SETUP_LAST;
    endcase
  end

  assign phase_end = (phase != PH_IDLE) && (cnt == cnt_last);
  assign oDONE     = (phase == PH_HOLD) && phase_end;
  assign accept    = iSTART && ((phase == PH_IDLE) || oDONE);

  // RS/DATA are captured once per byte and held through HOLD.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      phase <= phase_nxt;
      if (accept || phase_end) cnt <= '0;
      else if (phase != PH_IDLE) cnt <= cnt + CNT_W'(1);
      if (accept) begin
        LCD_RS   <= iRS;
        LCD_DATA <= iDATA;
        long_q   <= iLONG;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    if (accept) begin
      phase_nxt = PH_SETUP;
    end else if (phase_end) begin
      case (phase)
        PH_SETUP: phase_nxt = PH_PULSE;
        PH_PULSE: phase_nxt = PH_HOLD;
        default:  phase_nxt = PH_IDLE;
      endcase
    end
  end

  always_comb LCD_EN = (phase == PH_PULSE);

endmodule

// File: rtl/lcd_hex_display.sv
// HD44780 8-bit write-only driver: power-up init, then shows NUM_DIGITS hex digits
// of iVALUE on one row, rewritten on iUPDATE or (optionally) whenever the value changes.
module lcd_hex_display
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int NUM_DIGITS   = 8,
  parameter int ROW          = 0,
  parameter int COL_START    = 0,
  parameter int AUTO_REFRESH = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic                    iUPDATE,
  output logic                    oREADY,
  output logic [7:0]              LCD_DATA,
  output logic                    LCD_RW,
  output logic                    LCD_EN,
  output logic                    LCD_RS
);

  localparam int T_US  = CLK_FREQ_HZ / 1000000;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(T_CNT_MAX_US * T_US + 1);
  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(T_PWR_US * T_US - 1);
  localparam logic [3:0]       LAST_CHAR  = 4'(NUM_DIGITS - 1);
  localparam logic [7:0]       DDRAM_ADDR = LCD_CMD_DDRAM | 8'(ROW * 64 + COL_START);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || COL_START < 0 || COL_START + NUM_DIGITS > 16)
  begin : g_bad_geometry
    $error("lcd_hex_display: digits do not fit in a 16-column row");
  end
  if (CLK_FREQ_HZ < 1000000 || CLK_FREQ_HZ % 1000000 != 0) begin : g_bad_clock
    $error("lcd_hex_display: CLK_FREQ_HZ must be a whole number of MHz");
  end
  if (ROW != 0 && ROW != 1) begin : g_bad_row
    $error("lcd_hex_display: ROW must be 0 or 1");
  end

  lcd_state_e       state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [CNT_W-1:0] pwr_cnt;
  logic [VAL_W-1:0] shadow;
  logic [3:0]       nib;
  logic             pending, pwr_last, req, launch_row;
  logic             wr_start, wr_rs, wr_long, wr_done;
  logic [7:0]       wr_data;

  assign pwr_last   = (pwr_cnt == PWR_LAST);
  assign req        = iUPDATE || ((AUTO_REFRESH != 0) && (iVALUE != shadow));
  assign launch_row = (state_nxt == ST_SET_ADDR) && (state != ST_SET_ADDR);
  assign LCD_RW     = 1'b0;

  // Shadow is the only source of characters, so a row is never torn by iVALUE changes.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= ST_PWR_WAIT;
      idx     <= '0;
      pwr_cnt <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pwr_cnt <= (state == ST_PWR_WAIT && !pwr_last) ? pwr_cnt + CNT_W'(1) : '0;
      if (launch_row) begin
        shadow  <= iVALUE;
        pending <= 1'b0;
      end else if (iUPDATE && state != ST_IDLE) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_PWR_WAIT: if (pwr_last) begin
        state_nxt = ST_INIT;
        idx_nxt   = '0;
      end
      ST_INIT: if (wr_done) begin
        if (idx == 4'd3) state_nxt = ST_SET_ADDR;
        else             idx_nxt   = idx + 4'd1;
      end
      ST_IDLE: if (req) state_nxt = ST_SET_ADDR;
      ST_SET_ADDR: if (wr_done) begin
        state_nxt = ST_WRITE_CHAR;
        idx_nxt   = '0;
      end
      ST_WRITE_CHAR: if (wr_done) begin
        if (idx == LAST_CHAR) state_nxt = (pending || req) ? ST_SET_ADDR : ST_IDLE;
        else                  idx_nxt   = idx + 4'd1;
      end
      default: state_nxt = ST_PWR_WAIT;
    endcase
  end

  // The next byte is issued in the same cycle the previous one completes,
  // so its content is selected from the upcoming state and index.
  always_comb begin
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_long  = 1'b0;
    wr_data  = DDRAM_ADDR;
    nib      = '0;
    oREADY   = (state == ST_IDLE) && !pending;
    case (state)
      ST_PWR_WAIT: wr_start = pwr_last;
      ST_IDLE:     wr_start = req;
      default:     wr_start = wr_done && (state_nxt != ST_IDLE);
    endcase
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx_nxt == 4'(k)) nib = shadow[VAL_W-4-4*k +: 4];
    case (state_nxt)
      ST_INIT: begin
        case (idx_nxt[1:0])
          2'd0:    wr_data = LCD_CMD_FUNC_SET;
          2'd1:    wr_data = LCD_CMD_DISP_ON;
          2'd2:    begin wr_data = LCD_CMD_CLEAR; wr_long = 1'b1; end
          default: wr_data = LCD_CMD_ENTRY;
        endcase
      end
      ST_WRITE_CHAR: begin
        wr_rs   = 1'b1;
        wr_data = hex2ascii(nib);
      end
      default: wr_data = DDRAM_ADDR;
    endcase
  end

  lcd_byte_writer #(
    .T_US(T_US)
  ) u_writer (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iSTART  (wr_start),
    .iRS     (wr_rs),
    .iDATA   (wr_data),
    .iLONG   (wr_long),
    .oDONE   (wr_done),
    .LCD_DATA(LCD_DATA),
    .LCD_RS  (LCD_RS),
    .LCD_EN  (LCD_EN)
  );

endmodule
